mm_bridge: RTL and testbench

MM_BRIDGE -- requirements
Module: mm_bridge

---
 rtl/mm_bridge_pkg.sv | 6 +
 rtl/mm_addr_decode.sv | 24 ++
 rtl/mm_bridge.sv | 118 +++++++++++
 tb/tb_mm_bridge.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mm_bridge_pkg.sv
// mm_bridge_pkg: FSM states and constants shared by the mm_bridge slice.
package mm_bridge_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;
    localparam logic [2:0] MM_WINDOW = 3'b111;
    localparam logic [63:0] TIMEOUT_RDATA = 64'h0;
endpackage

// File: rtl/mm_addr_decode.sv
// mm_addr_decode: MM window check, channel index extraction and reject flag.
module mm_addr_decode
    import mm_bridge_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 16,
    parameter int CH_SEL_LSB = 4,
    parameter int IDX_W      = 2
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              re_i,
    input  logic              we_i,
    output logic              in_win_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              bad_o
);
    localparam logic [IDX_W:0] NUM_CH_L = (IDX_W + 1)'(NUM_CH);
    logic unused_addr;
    assign unused_addr = ^addr_i;
    assign in_win_o    = addr_i[ADDR_W-1 -: 3] == MM_WINDOW;
    // A single channel has no index bits; every in-window access targets channel 0.
    assign idx_o       = (NUM_CH == 1) ? '0 : addr_i[CH_SEL_LSB +: IDX_W];
    assign bad_o       = ({1'b0, idx_o} >= NUM_CH_L) || (re_i && we_i);
endmodule

// File: rtl/mm_bridge.sv
// mm_bridge: CPU memory-mapped request to one-hot peripheral channel bridge; MM_BRIDGE_TIMEOUT_EN adds an ack timeout.
module mm_bridge
    import mm_bridge_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int CH_SEL_LSB  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic                     cpu_re,
    input  logic                     cpu_we,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_rvld,
    output logic                     cpu_stall,
    output logic                     cpu_err,
    output logic [NUM_CH-1:0]        ch_req,
    output logic                     ch_we,
    output logic [CH_SEL_LSB-1:0]    ch_addr,
    output logic [DATA_W-1:0]        ch_wdata,
    input  logic [NUM_CH-1:0]        ch_ack,
    input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
    output logic [7:0]               err_cnt
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d, dec_idx;
    logic [CH_SEL_LSB-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  we_q, we_d, rvld_q, rvld_d, err_q, err_d;
    logic                  in_win, bad, req_go, accept, ack, timeout;

    mm_addr_decode #(
        .NUM_CH    (NUM_CH),
        .ADDR_W    (ADDR_W),
        .CH_SEL_LSB(CH_SEL_LSB),
        .IDX_W     (IDX_W)
    ) u_dec (
        .addr_i  (cpu_addr),
        .re_i    (cpu_re),
        .we_i    (cpu_we),
        .in_win_o(in_win),
        .idx_o   (dec_idx),
        .bad_o   (bad)
    );

    assign req_go = (state_q == ST_IDLE) && in_win && (cpu_re || cpu_we);
    assign accept = req_go && !bad;
    assign ack    = (state_q == ST_REQ) && ch_ack[idx_q];

`ifdef MM_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) cnt_q <= (rst || state_q != ST_REQ || ack) ? '0 : cnt_q + 1'b1;
    assign timeout = (state_q == ST_REQ) && !ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rvld_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rvld_q    <= rvld_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = (state_q == ST_IDLE) ? (accept ? ST_REQ : ST_IDLE)
                  : (state_q == ST_REQ)  ? ((ack || timeout) ? ST_RESP : ST_REQ)
                  : ST_IDLE;
        idx_d     = accept ? dec_idx : idx_q;
        addr_d    = accept ? cpu_addr[CH_SEL_LSB-1:0] : addr_q;
        we_d      = accept ? cpu_we : we_q;
        wdata_d   = accept ? cpu_wdata : wdata_q;
        rvld_d    = !we_q && (ack || timeout);
        rdata_d   = (!we_q && ack)     ? ch_rdata[DATA_W*int'(idx_q) +: DATA_W]
                  : (!we_q && timeout) ? TIMEOUT_RDATA[DATA_W-1:0]
                  : rdata_q;
        err_d     = (req_go && bad) || timeout;
        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_comb begin
        ch_req    = (state_q == ST_REQ) ? (NUM_CH'(1) << idx_q) : '0;
        cpu_stall = accept || (state_q == ST_REQ);
    end

    assign cpu_rdata = rdata_q;
    assign cpu_rvld  = rvld_q;
    assign cpu_err   = err_q;
    assign ch_we     = we_q;
    assign ch_addr   = addr_q;
    assign ch_wdata  = wdata_q;
    assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_mm_bridge.sv
// tb_mm_bridge: per-cycle vector table for mm_bridge (NUM_CH=3, TIMEOUT_CYC=8) plus a timeout sequence.
module tb_mm_bridge;
    logic        clk = 1'b0;
    logic        rst, cpu_re, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, ch_wdata;
    logic        cpu_rvld, cpu_stall, cpu_err, ch_we;
    logic [2:0]  ch_req, ch_ack;
    logic [3:0]  ch_addr;
    logic [47:0] ch_rdata;
    logic [7:0]  err_cnt;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    mm_bridge #(
        .NUM_CH     (3),
        .DATA_W     (16),
        .ADDR_W     (16),
        .CH_SEL_LSB (4),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_addr (cpu_addr),
        .cpu_re   (cpu_re),
        .cpu_we   (cpu_we),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_rvld (cpu_rvld),
        .cpu_stall(cpu_stall),
        .cpu_err  (cpu_err),
        .ch_req   (ch_req),
        .ch_we    (ch_we),
        .ch_addr  (ch_addr),
        .ch_wdata (ch_wdata),
        .ch_ack   (ch_ack),
        .ch_rdata (ch_rdata),
        .err_cnt  (err_cnt)
    );

    typedef struct {
        logic [2:0]  ctl;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [2:0]  ack;
        logic [2:0]  req;
        logic [2:0]  flg;
        logic [15:0] rdata;
        logic [7:0]  ecnt;
        logic        we_e;
        logic [3:0]  caddr_e;
        logic [15:0] cwdata_e;
    } vec_t;

    localparam int NV = 24;
    vec_t v[NV];

    // ctl = {rst, re, we}; flg = {stall, rvld, err}
    function automatic vec_t row(input logic [2:0] ctl, input logic [15:0] a, wd,
                                 input logic [2:0] ak, q, f, input logic [15:0] rd,
                                 input logic [7:0] ec);
        vec_t r;
        r.ctl = ctl; r.addr = a; r.wdata = wd; r.ack = ak; r.req = q; r.flg = f;
        r.rdata = rd; r.ecnt = ec; r.we_e = 1'b0; r.caddr_e = 4'h0; r.cwdata_e = 16'h0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int n;
        ch_rdata = {16'hC2C2, 16'h1234, 16'hA0A0};
        v[0]  = row(3'b000, 16'h0000, 16'h0000, 3'b000, 3'b000, 3'b000, 16'h0000, 8'd0);
        v[1]  = row(3'b010, 16'hE010, 16'h0000, 3'b000, 3'b000, 3'b100, 16'h0000, 8'd0);
        v[2]  = row(3'b000, 16'h0000, 16'h0000, 3'b000, 3'b010, 3'b100, 16'h0000, 8'd0);
        v[3]  = row(3'b000, 16'h0000, 16'h0000, 3'b010, 3'b010, 3'b100, 16'h0000, 8'd0);
        v[4]  = row(3'b000, 16'h0000, 16'h0000, 3'b000, 3'b000, 3'b010, 16'h1234, 8'd0);
        v[5]  = row(3'b000, 16'h0000, 16'h0000, 3'b000, 3'b000, 3'b000, 16'h1234, 8'd0);
        v[6]  = row(3'b001, 16'hE025, 16'hBEEF, 3'b000, 3'b000, 3'b100, 16'h1234, 8'd0);
        v[7]  = row(3'b000, 16'h0000, 16'h0000, 3'b100, 3'b100, 3'b100, 16'h1234, 8'd0);
        v[7].we_e = 1'b1; v[7].caddr_e = 4'h5; v[7].cwdata_e = 16'hBEEF;
        v[8]  = row(3'b000, 16'h0000, 16'h0000, 3'b000, 3'b000, 3'b000, 16'h1234, 8'd0);
        v[9]  = row(3'b010, 16'h2000, 16'h0000, 3'b000, 3'b000, 3'b000, 16'h1234, 8'd0);
        v[10] = row(3'b000, 16'h0000, 16'h0000, 3'b000, 3'b000, 3'b000, 16'h1234, 8'd0);
        v[11] = row(3'b010, 16'hE030, 16'h0000, 3'b000, 3'b000, 3'b000, 16'h1234, 8'd0);
        v[12] = row(3'b000, 16'h0000, 16'h0000, 3'b000, 3'b000, 3'b001, 16'h1234, 8'd1);
        v[13] = row(3'b011, 16'hE010, 16'h0000, 3'b000, 3'b000, 3'b000, 16'h1234, 8'd1);
        v[14] = row(3'b000, 16'h0000, 16'h0000, 3'b000, 3'b000, 3'b001, 16'h1234, 8'd2);
        v[15] = row(3'b000, 16'h0000, 16'h0000, 3'b000, 3'b000, 3'b000, 16'h1234, 8'd2);
        v[16] = row(3'b010, 16'hE000, 16'h0000, 3'b100, 3'b000, 3'b100, 16'h1234, 8'd2);
        v[17] = row(3'b000, 16'h0000, 16'h0000, 3'b100, 3'b001, 3'b100, 16'h1234, 8'd2);
        v[18] = row(3'b100, 16'h0000, 16'h0000, 3'b000, 3'b001, 3'b100, 16'h1234, 8'd2);
        v[19] = row(3'b000, 16'h0000, 16'h0000, 3'b000, 3'b000, 3'b000, 16'h0000, 8'd0);
        v[20] = row(3'b010, 16'hE020, 16'h0000, 3'b000, 3'b000, 3'b100, 16'h0000, 8'd0);
        v[21] = row(3'b000, 16'h0000, 16'h0000, 3'b100, 3'b100, 3'b100, 16'h0000, 8'd0);
        v[22] = row(3'b000, 16'h0000, 16'h0000, 3'b100, 3'b000, 3'b010, 16'hC2C2, 8'd0);
        v[23] = row(3'b000, 16'h0000, 16'h0000, 3'b000, 3'b000, 3'b000, 16'hC2C2, 8'd0);

        rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; ch_ack = '0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            {rst, cpu_re, cpu_we} = v[i].ctl;
            cpu_addr  = v[i].addr;
            cpu_wdata = v[i].wdata;
            ch_ack    = v[i].ack;
            #1;
            chk($sformatf("r%0d ch_req", i), 32'(ch_req), 32'(v[i].req));
            chk($sformatf("r%0d stall", i), 32'(cpu_stall), 32'(v[i].flg[2]));
            chk($sformatf("r%0d rvld", i), 32'(cpu_rvld), 32'(v[i].flg[1]));
            chk($sformatf("r%0d err", i), 32'(cpu_err), 32'(v[i].flg[0]));
            chk($sformatf("r%0d rdata", i), 32'(cpu_rdata), 32'(v[i].rdata));
            chk($sformatf("r%0d err_cnt", i), 32'(err_cnt), 32'(v[i].ecnt));
            if (v[i].req != 3'b000) begin
                chk($sformatf("r%0d ch_we", i), 32'(ch_we), 32'(v[i].we_e));
                chk($sformatf("r%0d ch_addr", i), 32'(ch_addr), 32'(v[i].caddr_e));
                chk($sformatf("r%0d ch_wdata", i), 32'(ch_wdata), 32'(v[i].cwdata_e));
            end
        end

        // Read of ch1 that is never acknowledged.
        @(negedge clk);
        rst = 1'b0; cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hE010; ch_ack = '0;
        @(negedge clk);
        cpu_re = 1'b0; cpu_addr = '0;
        #1;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (ch_req !== 3'b010) break;
            n++;
            @(negedge clk);
            #1;
        end
`ifdef MM_BRIDGE_TIMEOUT_EN
        chk("timeout req cycles", 32'(n), 32'd8);
        chk("timeout req dropped", 32'(ch_req), 32'd0);
        chk("timeout rvld", 32'(cpu_rvld), 32'd1);
        chk("timeout err", 32'(cpu_err), 32'd1);
        chk("timeout rdata", 32'(cpu_rdata), 32'd0);
        chk("timeout err_cnt", 32'(err_cnt), 32'd1);
        @(negedge clk);
        #1;
        chk("after timeout rvld", 32'(cpu_rvld), 32'd0);
        chk("after timeout err", 32'(cpu_err), 32'd0);
`else
        chk("no timeout req cycles", 32'(n), 32'd1000);
        chk("no timeout err", 32'(cpu_err), 32'd0);
        chk("no timeout rvld", 32'(cpu_rvld), 32'd0);
        chk("no timeout stall", 32'(cpu_stall), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset drops req", 32'(ch_req), 32'd0);
        chk("reset no rvld", 32'(cpu_rvld), 32'd0);
        chk("reset no err", 32'(cpu_err), 32'd0);
        chk("reset no stall", 32'(cpu_stall), 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
